// File: rtl/uart_tx_fifo_if.sv
// Byte-push and status interface for the buffered UART transmitter.
// The master side pushes bytes and watches status. The slave side is the transmitter itself.
interface uart_tx_fifo_if #(
  parameter int unsigned PTR_W = 4
);
  logic [7:0]     tx_data;
  logic           tx_wen;
  logic           tx;
  logic           busy;
  logic           fifo_full;
  logic [PTR_W:0] fifo_count;
  logic           overflow;

  modport master (
    output tx_data,
    output tx_wen,
    input  tx,
    input  busy,
    input  fifo_full,
    input  fifo_count,
    input  overflow
  );

  modport slave (
    input  tx_data,
    input  tx_wen,
    output tx,
    output busy,
    output fifo_full,
    output fifo_count,
    output overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter (LSB first) fed by a byte FIFO.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between data and stop
// (frames become 11 bit periods long). Without it, frames are 10 bit periods long.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PTR_W        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned    BaudW    = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             overflow_q;
  logic [7:0]       head;
  logic             push;
  logic             pop;

  // Serialiser state
  state_e           state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             busy_d;
  logic             baud_zero;
  logic             at_frame_edge;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  // Pop/push decisions and next count. A pop frees a slot the same cycle, so a push while
  // full is still accepted when it coincides with a pop.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    baud_zero     = (baud_q == '0);
    at_frame_edge = (state_q == StIdle) || ((state_q == StStop) && baud_zero);
    pop           = (count_q != '0) && at_frame_edge;
    push          = bus.tx_wen && ((count_q != DepthCnt) || pop);
    count_d       = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    // Next state is idle only when sitting at a frame edge with nothing to pop.
    busy_d = !(at_frame_edge && !pop) || (count_d != '0);
  end

  // FIFO pointers, count and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (bus.tx_wen && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage. A same-cycle write to the slot being popped is safe because the
  // pop reads the old contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

  // Frame sequencer with registered tx and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q  <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
            tx_q     <= 1'b0;
            baud_q   <= BaudLast;
            state_q  <= StStart;
          end
        end

        StStart: begin
          if (baud_zero) begin
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            baud_q  <= BaudLast;
            state_q <= StData;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end

        StData: begin
          if (baud_zero) begin
            baud_q <= BaudLast;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= StParity;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (baud_zero) begin
            tx_q    <= 1'b1;
            baud_q  <= BaudLast;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`endif

        StStop: begin
          if (baud_zero) begin
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift_q  <= head;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^head;
`endif
              tx_q     <= 1'b0;
              baud_q   <= BaudLast;
              state_q  <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_full  = (count_q == DepthCnt);
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at 4 clocks per bit, 16-entry FIFO.
module tb_uart_tx_fifo;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 16;
  localparam int unsigned PtrW  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int FrameLen = FrameBits * Cpb;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   low_seen;

  uart_tx_fifo_if #(.PTR_W(PtrW)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth),
    .PTR_W       (PtrW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.tx_data = b;
    bus.tx_wen  = 1'b1;
    tick();
    bus.tx_wen  = 1'b0;
  endtask

  task automatic do_reset();
    bus.tx_wen = 1'b0;
    rst_n      = 1'b0;
    repeat (2) tick();
    rst_n      = 1'b1;
  endtask

  // Expected line level for bit period k of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called just after the edge where tx fell; samples mid-bit, ends 2 cycles before next start.
  task automatic check_frame(input string tag, input logic [7:0] b);
    for (int k = 0; k < FrameBits; k++) begin
      repeat ((k == 0) ? 2 : 4) tick();
      check($sformatf("%s bit%0d", tag, k), 32'(bus.tx), 32'(frame_bit(b, k)));
    end
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_wen  = 1'b0;

    // Reset values, checked while reset is held
    #1 rst_n = 1'b0;
    #2;
    check("rst tx", 32'(bus.tx), 32'd1);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst full", 32'(bus.fifo_full), 32'd0);
    check("rst count", 32'(bus.fifo_count), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("idle tx", 32'(bus.tx), 32'd1);
    check("idle busy", 32'(bus.busy), 32'd0);

    // Single byte 0x55: tx falls one edge after the push is sampled
    push(8'h55);
    check("t2 queued count", 32'(bus.fifo_count), 32'd1);
    check("t2 busy", 32'(bus.busy), 32'd1);
    check("t2 tx before start", 32'(bus.tx), 32'd1);
    tick();
    check("t2 start", 32'(bus.tx), 32'd0);
    check("t2 popped count", 32'(bus.fifo_count), 32'd0);
    check_frame("t2", 8'h55);
    tick();
    check("t2 busy late stop", 32'(bus.busy), 32'd1);
    tick();
    check("t2 busy done", 32'(bus.busy), 32'd0);
    check("t2 tx idle", 32'(bus.tx), 32'd1);

    // Back-to-back 0xA3, 0x0F: contiguous frames
    push(8'hA3);
    push(8'h0F);
    check("t3 start a", 32'(bus.tx), 32'd0);
    check("t3 count", 32'(bus.fifo_count), 32'd1);
    check_frame("t3a", 8'hA3);
    tick();
    check("t3 stop a end", 32'(bus.tx), 32'd1);
    tick();
    check("t3 start b", 32'(bus.tx), 32'd0);
    check("t3 count b", 32'(bus.fifo_count), 32'd0);
    check("t3 busy b", 32'(bus.busy), 32'd1);
    check_frame("t3b", 8'h0F);
    repeat (2) tick();
    check("t3 busy done", 32'(bus.busy), 32'd0);
    check("t3 tx idle", 32'(bus.tx), 32'd1);

    // 17 pushes from reset: one goes to the shifter, 16 fill the FIFO
    do_reset();
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
    check("t4 count full", 32'(bus.fifo_count), 32'd16);
    check("t4 full", 32'(bus.fifo_full), 32'd1);
    check("t4 no overflow", 32'(bus.overflow), 32'd0);
    // Push landing on the stop->start pop of the second frame is accepted
    repeat (FrameLen - 16) tick();
    push(8'h77);
    check("t5 start 0x11", 32'(bus.tx), 32'd0);
    check("t5 count", 32'(bus.fifo_count), 32'd16);
    check("t5 full", 32'(bus.fifo_full), 32'd1);
    check("t5 no overflow", 32'(bus.overflow), 32'd0);
    // Push while full with no pop is dropped
    push(8'hEE);
    check("t4 drop overflow", 32'(bus.overflow), 32'd1);
    check("t4 drop count", 32'(bus.fifo_count), 32'd16);
    check("t4 drop full", 32'(bus.fifo_full), 32'd1);
    repeat (FrameLen - 1) tick();
    check("t5 start 0x12", 32'(bus.tx), 32'd0);
    for (int i = 2; i < 17; i++) begin
      check_frame($sformatf("t5 byte%0d", i), 8'h10 + 8'(i));
      repeat (2) tick();
    end
    check_frame("t5 byte77", 8'h77);
    repeat (2) tick();
    check("t5 drained busy", 32'(bus.busy), 32'd0);
    check("t5 drained tx", 32'(bus.tx), 32'd1);
    check("t5 drained count", 32'(bus.fifo_count), 32'd0);

    // Reset mid-DATA of 0xFF with 3 bytes queued
    do_reset();
    push(8'hFF);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check("t6 queued", 32'(bus.fifo_count), 32'd3);
    repeat (7) tick();
    check("t6 mid data busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6 rst tx", 32'(bus.tx), 32'd1);
    check("t6 rst busy", 32'(bus.busy), 32'd0);
    check("t6 rst count", 32'(bus.fifo_count), 32'd0);
    #2 rst_n = 1'b1;
    low_seen = 0;
    for (int i = 0; i < 3 * FrameLen; i++) begin
      tick();
      if (bus.tx !== 1'b1) low_seen++;
    end
    check("t6 no frame after reset", 32'(low_seen), 32'd0);
    check("t6 idle busy", 32'(bus.busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has odd weight (bit 1), 0x03 even (bit 0); 44-cycle spacing
    push(8'h07);
    push(8'h03);
    check("par start a", 32'(bus.tx), 32'd0);
    check_frame("par07", 8'h07);
    tick();
    check("par stop a end", 32'(bus.tx), 32'd1);
    tick();
    check("par start b", 32'(bus.tx), 32'd0);
    check_frame("par03", 8'h03);
    repeat (2) tick();
    check("par busy done", 32'(bus.busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
